// File: rtl/ex_mem_if.sv
// EX/MEM bus: EX-side inputs to the pipeline register and MEM-side outputs.
// When EXMEM_PERF_EN is defined the interface also carries the two
// MEM-stage performance counters (InstrCnt_MEM, BubbleCnt_MEM).
interface ex_mem_if;
    logic        Valid_EX;
    logic [31:0] ALUResult_EX;
    logic [31:0] RD2_EX;
    logic [31:0] PC_EX;
    logic [4:0]  A3_EX;
    logic        RegWrite_EX;
    logic        MemWrite_EX;
    logic [1:0]  WDSel_EX;
    logic [1:0]  Tnew_EX;

    logic        Valid_MEM;
    logic [31:0] ALUResult_MEM;
    logic [31:0] RD2_MEM;
    logic [31:0] PC_MEM;
    logic [31:0] PC8_MEM;
    logic [4:0]  A3_MEM;
    logic        RegWrite_MEM;
    logic        MemWrite_MEM;
    logic [1:0]  WDSel_MEM;
    logic [1:0]  Tnew_MEM;
    logic [31:0] FwdData_MEM;
    logic        FwdValid_MEM;
`ifdef EXMEM_PERF_EN
    logic [31:0] InstrCnt_MEM;
    logic [31:0] BubbleCnt_MEM;
`endif

    // EX stage side: drives the _EX fields, observes the MEM outputs.
    modport master (
        output Valid_EX, ALUResult_EX, RD2_EX, PC_EX, A3_EX,
               RegWrite_EX, MemWrite_EX, WDSel_EX, Tnew_EX,
        input  Valid_MEM, ALUResult_MEM, RD2_MEM, PC_MEM, PC8_MEM, A3_MEM,
               RegWrite_MEM, MemWrite_MEM, WDSel_MEM, Tnew_MEM,
               FwdData_MEM, FwdValid_MEM
`ifdef EXMEM_PERF_EN
        , input InstrCnt_MEM, BubbleCnt_MEM
`endif
    );

    // Pipeline register side: consumes the _EX fields, produces MEM outputs.
    modport slave (
        input  Valid_EX, ALUResult_EX, RD2_EX, PC_EX, A3_EX,
               RegWrite_EX, MemWrite_EX, WDSel_EX, Tnew_EX,
        output Valid_MEM, ALUResult_MEM, RD2_MEM, PC_MEM, PC8_MEM, A3_MEM,
               RegWrite_MEM, MemWrite_MEM, WDSel_MEM, Tnew_MEM,
               FwdData_MEM, FwdValid_MEM
`ifdef EXMEM_PERF_EN
        , output InstrCnt_MEM, BubbleCnt_MEM
`endif
    );
endinterface

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register of the five-stage MIPS core.
// Captures EX results and write-back control, presents them to MEM, and
// produces the MEM-stage forwarding source (ALU result or PC+8) plus its
// validity for the hazard/forward unit.
// Edge priority: reset (active-low, synchronous) > flush > hold (!en) > load.
// Optional macro EXMEM_PERF_EN adds instruction and bubble counters.
module ex_mem_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     en,
    input  logic     flush,
    ex_mem_if.slave  bus
);

    logic        valid_q,    valid_d;
    logic [31:0] alu_q,      alu_d;
    logic [31:0] rd2_q,      rd2_d;
    logic [31:0] pc_q,       pc_d;
    logic [4:0]  a3_q,       a3_d;
    logic        regwrite_q, regwrite_d;
    logic        memwrite_q, memwrite_d;
    logic [1:0]  wdsel_q,    wdsel_d;
    logic [1:0]  tnew_q,     tnew_d;

    logic        do_bubble;
    logic        do_load;
    logic [31:0] pc8;

    // A bubble is either an explicit flush (which wins over a stall) or a
    // normal load of an empty EX slot; a real load needs en and a valid slot.
    assign do_bubble = flush | (en & ~bus.Valid_EX);
    assign do_load   = ~flush & en & bus.Valid_EX;

    // Next-state selection: bubble, load, or hold (default).
    always_comb begin
        valid_d    = valid_q;
        alu_d      = alu_q;
        rd2_d      = rd2_q;
        pc_d       = pc_q;
        a3_d       = a3_q;
        regwrite_d = regwrite_q;
        memwrite_d = memwrite_q;
        wdsel_d    = wdsel_q;
        tnew_d     = tnew_q;
        if (do_bubble) begin
            valid_d    = 1'b0;
            alu_d      = 32'd0;
            rd2_d      = 32'd0;
            pc_d       = RESET_PC;
            a3_d       = 5'd0;
            regwrite_d = 1'b0;
            memwrite_d = 1'b0;
            wdsel_d    = 2'd0;
            tnew_d     = 2'd0;
        end else if (do_load) begin
            valid_d    = 1'b1;
            alu_d      = bus.ALUResult_EX;
            rd2_d      = bus.RD2_EX;
            pc_d       = bus.PC_EX;
            a3_d       = bus.A3_EX;
            regwrite_d = bus.RegWrite_EX;
            memwrite_d = bus.MemWrite_EX;
            wdsel_d    = bus.WDSel_EX;
            // One cycle has elapsed since EX; saturate at zero.
            tnew_d     = (bus.Tnew_EX == 2'd0) ? 2'd0 : bus.Tnew_EX - 2'd1;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q    <= 1'b0;
            alu_q      <= 32'd0;
            rd2_q      <= 32'd0;
            pc_q       <= RESET_PC;
            a3_q       <= 5'd0;
            regwrite_q <= 1'b0;
            memwrite_q <= 1'b0;
            wdsel_q    <= 2'd0;
            tnew_q     <= 2'd0;
        end else begin
            valid_q    <= valid_d;
            alu_q      <= alu_d;
            rd2_q      <= rd2_d;
            pc_q       <= pc_d;
            a3_q       <= a3_d;
            regwrite_q <= regwrite_d;
            memwrite_q <= memwrite_d;
            wdsel_q    <= wdsel_d;
            tnew_q     <= tnew_d;
        end
    end

    // PC+8 is the link value for jal/jalr; wraps naturally modulo 2^32.
    assign pc8 = pc_q + 32'd8;

    assign bus.Valid_MEM     = valid_q;
    assign bus.ALUResult_MEM = alu_q;
    assign bus.RD2_MEM       = rd2_q;
    assign bus.PC_MEM        = pc_q;
    assign bus.PC8_MEM       = pc8;
    assign bus.A3_MEM        = a3_q;
    assign bus.RegWrite_MEM  = regwrite_q & valid_q;
    assign bus.MemWrite_MEM  = memwrite_q & valid_q;
    assign bus.WDSel_MEM     = wdsel_q;
    assign bus.Tnew_MEM      = tnew_q;
    // WDSel 3 is unused and falls back to the ALU result like WDSel 0.
    assign bus.FwdData_MEM   = (wdsel_q == 2'd2) ? pc8 : alu_q;
    // $0 is never a forwarding target; loads keep Tnew>=1 here so they drop out.
    assign bus.FwdValid_MEM  = valid_q & regwrite_q & (a3_q != 5'd0) & (tnew_q == 2'd0);

`ifdef EXMEM_PERF_EN
    logic [31:0] instr_cnt_q,  instr_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    // Count real instructions entering MEM and inserted bubbles.
    always_comb begin
        instr_cnt_d  = instr_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (do_load) begin
            instr_cnt_d = instr_cnt_q + 32'd1;
        end
        if (do_bubble) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            instr_cnt_q  <= 32'd0;
            bubble_cnt_q <= 32'd0;
        end else begin
            instr_cnt_q  <= instr_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bus.InstrCnt_MEM  = instr_cnt_q;
    assign bus.BubbleCnt_MEM = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// Testbench for ex_mem_reg: directed vector table, randomized run against a
// behavioural model, and (with EXMEM_PERF_EN) a counter sequence.
module tb_ex_mem_reg;

    logic clk;
    logic reset;
    logic en;
    logic flush;

    ex_mem_if bus ();

    ex_mem_reg #(.RESET_PC(32'h0000_3000)) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .flush (flush),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests;
    int n_fail;

    typedef struct {
        logic        rst;
        logic        en;
        logic        fl;
        logic        vl;
        logic [31:0] alu;
        logic [31:0] rd2;
        logic [31:0] pc;
        logic [4:0]  a3;
        logic        rw;
        logic        mw;
        logic [1:0]  wd;
        logic [1:0]  tn;
        logic        e_vl;
        logic [31:0] e_alu;
        logic [31:0] e_pc8;
        logic [1:0]  e_tn;
        logic        e_rw;
        logic        e_mw;
        logic        e_fv;
        logic        chk_fwd;
        logic [31:0] e_fwd;
    } vec_t;

    vec_t vecs[$];

    // Behavioural model state (what MEM should hold).
    logic        m_vl;
    logic [31:0] m_alu, m_rd2, m_pc;
    logic [4:0]  m_a3;
    logic        m_rw, m_mw;
    logic [1:0]  m_wd, m_tn;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic f, input logic v,
                         input logic [31:0] alu, input logic [31:0] rd2, input logic [31:0] pc,
                         input logic [4:0] a3, input logic rw, input logic mw,
                         input logic [1:0] wd, input logic [1:0] tn);
        reset            = r;
        en               = e;
        flush            = f;
        bus.Valid_EX     = v;
        bus.ALUResult_EX = alu;
        bus.RD2_EX       = rd2;
        bus.PC_EX        = pc;
        bus.A3_EX        = a3;
        bus.RegWrite_EX  = rw;
        bus.MemWrite_EX  = mw;
        bus.WDSel_EX     = wd;
        bus.Tnew_EX      = tn;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Spec-level model of one clock edge given the currently driven inputs.
    task automatic model_edge();
        if (!reset || flush || (en && !bus.Valid_EX)) begin
            m_vl = 0; m_alu = 0; m_rd2 = 0; m_pc = 32'h3000;
            m_a3 = 0; m_rw = 0; m_mw = 0; m_wd = 0; m_tn = 0;
        end else if (en) begin
            m_vl  = 1;
            m_alu = bus.ALUResult_EX;
            m_rd2 = bus.RD2_EX;
            m_pc  = bus.PC_EX;
            m_a3  = bus.A3_EX;
            m_rw  = bus.RegWrite_EX;
            m_mw  = bus.MemWrite_EX;
            m_wd  = bus.WDSel_EX;
            m_tn  = (bus.Tnew_EX > 0) ? bus.Tnew_EX - 2'd1 : 2'd0;
        end
    endtask

    task automatic check_model();
        logic [31:0] pc8;
        logic        fv;
        pc8 = m_pc + 32'd8;
        fv  = m_vl && m_rw && (m_a3 != 0) && (m_tn == 0);
        chk("rnd_valid", {31'd0, bus.Valid_MEM}, {31'd0, m_vl});
        chk("rnd_alu", bus.ALUResult_MEM, m_alu);
        chk("rnd_rd2", bus.RD2_MEM, m_rd2);
        chk("rnd_pc", bus.PC_MEM, m_pc);
        chk("rnd_pc8", bus.PC8_MEM, pc8);
        chk("rnd_a3", {27'd0, bus.A3_MEM}, {27'd0, m_a3});
        chk("rnd_rw", {31'd0, bus.RegWrite_MEM}, {31'd0, m_rw & m_vl});
        chk("rnd_mw", {31'd0, bus.MemWrite_MEM}, {31'd0, m_mw & m_vl});
        chk("rnd_tnew", {30'd0, bus.Tnew_MEM}, {30'd0, m_tn});
        chk("rnd_fwdvalid", {31'd0, bus.FwdValid_MEM}, {31'd0, fv});
        if (m_vl) begin
            chk("rnd_wdsel", {30'd0, bus.WDSel_MEM}, {30'd0, m_wd});
            chk("rnd_fwddata", bus.FwdData_MEM, (m_wd == 2'd2) ? pc8 : m_alu);
        end
    endtask

    initial begin
        vec_t v;
        n_tests = 0;
        n_fail  = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Directed vectors: inputs for one edge, outputs expected after it.
        v = '{0,1,0,1, 32'hdead, 32'h1, 32'h4000, 5'd3, 1,1, 2'd2, 2'd1,
              0, 32'h0, 32'h3008, 2'd0, 0,0,0, 1, 32'h0};              vecs.push_back(v);
        vecs.push_back(v);
        v = '{1,1,0,1, 32'h1234, 32'h0, 32'h3004, 5'd0, 0,0, 2'd0, 2'd0,
              1, 32'h1234, 32'h300C, 2'd0, 0,0,0, 1, 32'h1234};        vecs.push_back(v);
        v = '{1,1,0,1, 32'h55, 32'h0, 32'h3010, 5'd31, 1,0, 2'd2, 2'd0,
              1, 32'h55, 32'h3018, 2'd0, 1,0,1, 1, 32'h3018};          vecs.push_back(v);
        v = '{1,1,0,1, 32'h100, 32'h0, 32'h3014, 5'd8, 1,0, 2'd1, 2'd2,
              1, 32'h100, 32'h301C, 2'd1, 1,0,0, 1, 32'h100};          vecs.push_back(v);
        v = '{1,1,0,1, 32'h77, 32'h0, 32'h3018, 5'd0, 1,0, 2'd0, 2'd0,
              1, 32'h77, 32'h3020, 2'd0, 1,0,0, 1, 32'h77};            vecs.push_back(v);
        v = '{1,1,0,1, 32'h200, 32'habc, 32'h301C, 5'd0, 0,1, 2'd0, 2'd0,
              1, 32'h200, 32'h3024, 2'd0, 0,1,0, 1, 32'h200};          vecs.push_back(v);
        v = '{1,0,1,1, 32'h999, 32'h5, 32'h5000, 5'd7, 1,1, 2'd2, 2'd0,
              0, 32'h0, 32'h3008, 2'd0, 0,0,0, 0, 32'h0};              vecs.push_back(v);
        v = '{1,1,0,1, 32'h1111, 32'h0, 32'h3020, 5'd5, 1,0, 2'd0, 2'd3,
              1, 32'h1111, 32'h3028, 2'd2, 1,0,0, 1, 32'h1111};        vecs.push_back(v);
        v = '{1,0,0,0, 32'hffff, 32'h1, 32'h7000, 5'd9, 0,1, 2'd2, 2'd1,
              1, 32'h1111, 32'h3028, 2'd2, 1,0,0, 1, 32'h1111};        vecs.push_back(v);
        v = '{1,0,0,1, 32'heeee, 32'h2, 32'h7004, 5'd1, 1,1, 2'd1, 2'd0,
              1, 32'h1111, 32'h3028, 2'd2, 1,0,0, 1, 32'h1111};        vecs.push_back(v);
        v = '{1,0,0,1, 32'hdddd, 32'h3, 32'h7008, 5'd2, 1,0, 2'd0, 2'd3,
              1, 32'h1111, 32'h3028, 2'd2, 1,0,0, 1, 32'h1111};        vecs.push_back(v);
        v = '{1,1,0,1, 32'h2222, 32'h0, 32'hFFFF_FFF8, 5'd5, 1,0, 2'd2, 2'd1,
              1, 32'h2222, 32'h0, 2'd0, 1,0,1, 1, 32'h0};              vecs.push_back(v);
        v = '{1,1,0,0, 32'h3333, 32'h3, 32'h3030, 5'd3, 1,1, 2'd0, 2'd0,
              0, 32'h0, 32'h3008, 2'd0, 0,0,0, 0, 32'h0};              vecs.push_back(v);
        v = '{0,0,1,1, 32'h4444, 32'h4, 32'h3034, 5'd4, 1,1, 2'd2, 2'd2,
              0, 32'h0, 32'h3008, 2'd0, 0,0,0, 1, 32'h0};              vecs.push_back(v);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].fl, vecs[i].vl, vecs[i].alu,
                  vecs[i].rd2, vecs[i].pc, vecs[i].a3, vecs[i].rw, vecs[i].mw,
                  vecs[i].wd, vecs[i].tn);
            tick();
            chk($sformatf("v%0d_valid", i), {31'd0, bus.Valid_MEM}, {31'd0, vecs[i].e_vl});
            chk($sformatf("v%0d_alu", i), bus.ALUResult_MEM, vecs[i].e_alu);
            chk($sformatf("v%0d_pc8", i), bus.PC8_MEM, vecs[i].e_pc8);
            chk($sformatf("v%0d_tnew", i), {30'd0, bus.Tnew_MEM}, {30'd0, vecs[i].e_tn});
            chk($sformatf("v%0d_rw", i), {31'd0, bus.RegWrite_MEM}, {31'd0, vecs[i].e_rw});
            chk($sformatf("v%0d_mw", i), {31'd0, bus.MemWrite_MEM}, {31'd0, vecs[i].e_mw});
            chk($sformatf("v%0d_fwdvalid", i), {31'd0, bus.FwdValid_MEM}, {31'd0, vecs[i].e_fv});
            if (vecs[i].chk_fwd)
                chk($sformatf("v%0d_fwddata", i), bus.FwdData_MEM, vecs[i].e_fwd);
        end

        // Last vector was a reset: model starts from the reset state.
        m_vl = 0; m_alu = 0; m_rd2 = 0; m_pc = 32'h3000;
        m_a3 = 0; m_rw = 0; m_mw = 0; m_wd = 0; m_tn = 0;

        // Randomized run against the behavioural model.
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] pc_r;
            pc_r = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF8 | {29'd0, 3'($urandom)}) : $urandom;
            drive(($urandom_range(0, 31) != 0),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 4) != 0),
                  $urandom, $urandom, pc_r,
                  ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                  1'($urandom), 1'($urandom), 2'($urandom), 2'($urandom));
            model_edge();
            tick();
            check_model();
        end

`ifdef EXMEM_PERF_EN
        // Counter sequence: 5 valid loads, 2 flushes, 1 hold, 1 empty load.
        drive(0, 1, 0, 1, 0, 0, 32'h3000, 0, 0, 0, 0, 0);
        tick();
        chk("perf_rst_instr", bus.InstrCnt_MEM, 32'd0);
        chk("perf_rst_bubble", bus.BubbleCnt_MEM, 32'd0);
        for (int k = 0; k < 5; k++) begin
            drive(1, 1, 0, 1, 32'(k), 0, 32'h3000 + 32'(4 * k), 5'd2, 1, 0, 0, 0);
            tick();
        end
        chk("perf_instr_after_loads", bus.InstrCnt_MEM, 32'd5);
        for (int k = 0; k < 2; k++) begin
            drive(1, 1, 1, 1, 0, 0, 32'h3100, 5'd2, 1, 0, 0, 0);
            tick();
        end
        drive(1, 0, 0, 1, 0, 0, 32'h3200, 5'd2, 1, 0, 0, 0);
        tick();
        chk("perf_bubble_hold", bus.BubbleCnt_MEM, 32'd2);
        drive(1, 1, 0, 0, 0, 0, 32'h3300, 5'd2, 1, 0, 0, 0);
        tick();
        chk("perf_instr", bus.InstrCnt_MEM, 32'd5);
        chk("perf_bubble", bus.BubbleCnt_MEM, 32'd3);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_mem_reg.md
Name: ex_mem_reg

Overview:
- EX/MEM pipeline register of the five-stage MIPS core; sits directly downstream of the EX stage.
- Captures the ALU result, forwarded store data, PC and write-back control from EX. Presents them to the MEM stage.
- Generates the MEM-stage forwarding source (ALUResult or PC+8) and its validity, which the hazard/forward unit uses to drive the EX/ID forward-select codes.

Parameters:
- RESET_PC, 32'h0000_3000, PC_MEM value after reset and on bubbles.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset. Sampled on the rising clk edge.
- en  in  1  register enable; 0 holds all state (MEM stall).
- flush  in  1  insert bubble into MEM on next edge.
- Valid_EX  in  1  EX slot holds a real instruction.
- ALUResult_EX  in  32  ALU output from EX.
- RD2_EX  in  32  forwarded rt data from EX (store data).
- PC_EX  in  32  PC of EX instruction.
- A3_EX  in  5  destination register number.
- RegWrite_EX  in  1  instruction writes GRF.
- MemWrite_EX  in  1  instruction writes DM.
- WDSel_EX  in  2  write-back source: 0 ALU, 1 DM, 2 PC+8.
- Tnew_EX  in  2  cycles until result available, as counted in EX.
- Valid_MEM  out  1  MEM slot valid.
- ALUResult_MEM  out  32  registered ALU result (DM address).
- RD2_MEM  out  32  registered store data.
- PC_MEM  out  32  registered PC.
- PC8_MEM  out  32  PC_MEM + 8.
- A3_MEM  out  5  registered destination.
- RegWrite_MEM  out  1  gated by Valid_MEM.
- MemWrite_MEM  out  1  gated by Valid_MEM.
- WDSel_MEM  out  2  registered.
- Tnew_MEM  out  2  registered decremented Tnew.
- FwdData_MEM  out  32  PC8_MEM if WDSel_MEM==2, else ALUResult_MEM.
- FwdValid_MEM  out  1  MEM can forward this cycle.

Behaviour:
- Reset (reset==0 at edge):
  - Valid_MEM=0, data regs=0, PC_MEM=RESET_PC, A3_MEM=0, WDSel_MEM=0, Tnew_MEM=0.
  - Reset overrides flush and en.
- Priority at each edge: reset > flush > !en (hold) > load.
- Load (en=1, flush=0):
  - All fields capture their _EX inputs.
  - Valid_MEM <= Valid_EX.
  - Tnew_MEM <= (Tnew_EX==0) ? 0 : Tnew_EX-1. Never underflows.
- Bubble (flush=1, or load with Valid_EX=0):
  - Valid_MEM=0, A3_MEM=0, RegWrite/MemWrite regs=0, Tnew_MEM=0.
  - Data regs and PC_MEM follow the same values as reset.
- flush=1 with en=0: flush wins; bubble is inserted.
- Hold (en=0, flush=0): every register keeps its value, including the decremented Tnew; no further decrement.
- Latency: exactly one cycle from _EX inputs to _MEM outputs.
- Combinational outputs:
  - PC8_MEM = PC_MEM + 32'd8, modulo 2^32 (wraps from 32'hFFFF_FFF8 to 0).
  - RegWrite_MEM = reg & Valid_MEM.
  - MemWrite_MEM = reg & Valid_MEM.
  - FwdValid_MEM = Valid_MEM & RegWrite_MEM & (A3_MEM!=0) & (Tnew_MEM==0).
  - WDSel_MEM==1 (load) always has Tnew_MEM>=1, so FwdValid_MEM=0 for loads.
  - WDSel_MEM==3 is treated as 0 for FwdData_MEM.
- A3_EX==0 with RegWrite_EX=1: captured as-is, but FwdValid_MEM stays 0.

Optional Feature:
- Macro: EXMEM_PERF_EN.
- When defined, adds two outputs, both cleared by reset, both holding when en=0, both wrapping modulo 2^32:
  - InstrCnt_MEM [31:0]: increments on every load edge with Valid_EX=1 and flush=0.
  - BubbleCnt_MEM [31:0]: increments on every edge that inserts a bubble (flush=1, or load with Valid_EX=0).
- When undefined, neither port nor the counters exist; all other behaviour is identical.

Test Plan:
- Reset, then load. Hold reset=0 for 2 cycles, then load ALUResult_EX=32'h1234, PC_EX=32'h3004, Valid_EX=1.
  - While reset: Valid_MEM=0, PC_MEM=32'h3000.
  - One cycle after release: ALUResult_MEM=32'h1234, PC8_MEM=32'h300C.
- jal forwarding. Load WDSel_EX=2, A3_EX=31, RegWrite_EX=1, Tnew_EX=0, PC_EX=32'h3010.
  - Required: FwdData_MEM=32'h3018, FwdValid_MEM=1.
- lw no-forward. Load WDSel_EX=1, A3_EX=8, Tnew_EX=2.
  - Required: Tnew_MEM=1, FwdValid_MEM=0.
  - Repeat with A3_EX=0, Tnew_EX=0, WDSel_EX=0: FwdValid_MEM=0.
- Flush during stall. Valid entry present; assert flush=1 and en=0 together.
  - Required: next cycle Valid_MEM=0, RegWrite_MEM=0, MemWrite_MEM=0.
- Hold. en=0 for 3 cycles while the _EX inputs change.
  - Required: all _MEM outputs unchanged, Tnew_MEM unchanged.
- With EXMEM_PERF_EN: 5 valid loads, 2 flushes, 1 hold, 1 load with Valid_EX=0.
  - Required: InstrCnt_MEM=5, BubbleCnt_MEM=3.
